soundrive_dac_sched: RTL and testbench



---
 rtl/soundrive_dac_sched_pkg.sv | 42 ++++
 rtl/soundrive_dac_sched_lj_shifter.sv | 83 ++++++++
 rtl/soundrive_dac_sched.sv | 103 ++++++++++
 tb/tb_soundrive_dac_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soundrive_dac_sched_pkg.sv
// common: shared types, constants and mix arithmetic for the Soundrive DAC
// frame scheduler.
//   dac_sample_t     signed 16-bit sample word as shifted out to the DAC
//   sched_state_t    scheduler FSM states (IDLE, RUN)
//   DAC_FRAME_BITS   BCK periods per frame (16 left + 16 right)
//   DAC_MID_SUM      midpoint of a two-channel sum (two silent 0x80 channels)
//   mix_pair()       two unsigned channels -> signed 16-bit sample
//   mix_quad()       four unsigned channels -> signed 16-bit mono sample
package common;

  typedef logic signed [15:0] dac_sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam int         DAC_FRAME_BITS   = 32;
  localparam logic [8:0] DAC_MID_SUM      = 9'd256;
  localparam logic [9:0] DAC_MONO_MID_SUM = 10'd512;

  // The subtraction wraps in 9 bits. For sums 0..510 the wrapped result is
  // exactly the two's-complement value of (sum - 256), so no saturation and
  // no sign extension are needed before the left shift.
  function automatic dac_sample_t mix_pair(input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] offset;
    offset = ({1'b0, a} + {1'b0, b}) - DAC_MID_SUM;
    return {offset, 7'b0};
  endfunction

  // Same idea with a 10-bit sum of all four channels (0..1020).
  function automatic dac_sample_t mix_quad(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c,
                                           input logic [7:0] d);
    logic [9:0] offset;
    offset = ({2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d}) - DAC_MONO_MID_SUM;
    return {offset, 6'b0};
  endfunction

endpackage

// File: rtl/soundrive_dac_sched_lj_shifter.sv
// dac_lj_shifter: left-justified serialiser for one 32-bit stereo frame.
// Owns the BCK divider, the bit index and the frame shift register.
//   clk28      system clock
//   rst        synchronous active-high reset
//   run        count and shift while high; hold while low
//   load       start a new frame from sample at this edge
//   sample     {left, right} frame word, MSB first
//   bck        bit clock, low for CLK_DIV cycles then high for CLK_DIV cycles
//   ws         word select (0 = left slot, 1 = right slot)
//   data       serial data, MSB first
//   frame_end  high in the cycle whose closing edge is the last falling BCK
module dac_lj_shifter
  import common::*;
#(
  parameter int CLK_DIV = 7
) (
  input  logic                      clk28,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      load,
  input  logic [DAC_FRAME_BITS-1:0] sample,
  output logic                      bck,
  output logic                      ws,
  output logic                      data,
  output logic                      frame_end
);

  localparam int         IDX_W    = $clog2(DAC_FRAME_BITS);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DAC_FRAME_BITS - 1);

  logic [7:0]                div_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [DAC_FRAME_BITS-1:0] shreg;
  logic                      div_wrap;
  logic                      bck_fall;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign bck_fall  = run && bck && div_wrap;
  assign frame_end = bck_fall && (bit_idx == IDX_LAST);

  // The word select simply follows the top bit of the index: bits 0..15 are
  // the left slot, 16..31 the right slot.
  assign ws   = bit_idx[IDX_W-1];
  assign data = shreg[DAC_FRAME_BITS-1];

  // NOTE: reset is sampled inside the clocked block (synchronous), and all
  // state updates use non-blocking assignments so every register sees the
  // pre-edge values of the others.
  always_ff @(posedge clk28) begin
    if (rst) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (load) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_idx <= '0;
      shreg   <= sample;
    end else if (run) begin
      if (div_wrap) begin
        div_cnt <= '0;
        bck     <= ~bck;
        // Only the falling BCK edge advances the bit; the rising edge is
        // where the DAC samples, so data must stay put across it.
        if (bck) begin
          if (bit_idx == IDX_LAST) begin
            // Frame over with no reload: fall back to the idle values.
            bit_idx <= '0;
            shreg   <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= {shreg[DAC_FRAME_BITS-2:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/soundrive_dac_sched.sv
// soundrive_dac_sched: shares one stereo left-justified serial DAC among the
// four 8-bit Covox/Soundrive channel registers. Once per frame it snapshots
// the channels, mixes them into signed 16-bit samples and shifts them out.
// Build option: define SOUNDRIVE_DAC_MONO_EN to send the mono mix of all four
// channels in both slots; otherwise the pairs are mixed to independent stereo.
//   clk28          28 MHz system clock
//   rst            synchronous active-high reset, priority over everything
//   en             run request, sampled at frame boundaries
//   ch_l0, ch_l1   left channel pair, unsigned, 0x80 = silence
//   ch_r0, ch_r1   right channel pair, unsigned, 0x80 = silence
//   dac_bck        bit clock
//   dac_ws         word select, 0 = left, 1 = right
//   dac_data       serial data, MSB first
//   sample_strobe  one-cycle pulse when a new snapshot is taken
//   busy           high while a frame is in flight
module soundrive_dac_sched
  import common::*;
#(
  parameter int CLK_DIV = 7
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  output logic       dac_bck,
  output logic       dac_ws,
  output logic       dac_data,
  output logic       sample_strobe,
  output logic       busy
);

  sched_state_t state;
  sched_state_t state_next;
  logic         load;
  logic         frame_end;
  dac_sample_t  left_mix;
  dac_sample_t  right_mix;

`ifdef SOUNDRIVE_DAC_MONO_EN
  assign left_mix  = mix_quad(ch_l0, ch_l1, ch_r0, ch_r1);
  assign right_mix = left_mix;
`else
  assign left_mix  = mix_pair(ch_l0, ch_l1);
  assign right_mix = mix_pair(ch_r0, ch_r1);
`endif

  // The snapshot is the shifter's frame register: the live channel values
  // are mixed and captured there on the load edge, so later changes on the
  // channel inputs cannot reach the frame in flight.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // en is only looked at here, so a frame is never cut short.
        if (frame_end) begin
          if (en) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state         <= IDLE;
      sample_strobe <= 1'b0;
    end else begin
      state         <= state_next;
      sample_strobe <= load;
    end
  end

  assign busy = (state == RUN);

  dac_lj_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk28     (clk28),
    .rst       (rst),
    .run       (busy),
    .load      (load),
    .sample    ({left_mix, right_mix}),
    .bck       (dac_bck),
    .ws        (dac_ws),
    .data      (dac_data),
    .frame_end (frame_end)
  );

endmodule

// File: tb/tb_soundrive_dac_sched.sv
// Self-checking bench for soundrive_dac_sched with CLK_DIV = 2.
// The DAC side is observed like a real left-justified receiver: bits are
// taken on rising BCK and assembled into 32-bit frames, then compared against
// sample words computed arithmetically from the channel values.
module tb_soundrive_dac_sched;

  localparam int          CLK_DIV   = 2;
  localparam int          BCK_PER   = 2 * CLK_DIV;
  localparam int          FRAME_CYC = 64 * CLK_DIV;
  localparam logic [31:0] WS_EXP    = 32'h0000FFFF;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ch_l0, ch_l1, ch_r0, ch_r1;
  logic       dac_bck, dac_ws, dac_data, sample_strobe, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Receiver capture state.
  logic [31:0] cap_data;
  logic [31:0] cap_ws;
  int          cap_strobes;
  int          per_min, per_max, last_rise;
  logic        prev_bck;

  // Words expected for the frame currently on the wire.
  logic [15:0] exp_l, exp_r;
  int          strobe_cyc;

  soundrive_dac_sched #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk28         (clk28),
    .rst           (rst),
    .en            (en),
    .ch_l0         (ch_l0),
    .ch_l1         (ch_l1),
    .ch_r0         (ch_r0),
    .ch_r1         (ch_r1),
    .dac_bck       (dac_bck),
    .dac_ws        (dac_ws),
    .dac_data      (dac_data),
    .sample_strobe (sample_strobe),
    .busy          (busy)
  );

  always #5 clk28 = ~clk28;
  always @(posedge clk28) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Sample value from the channel inputs, as plain signed arithmetic.
  function automatic logic [15:0] model_slot(input bit right);
    int v;
`ifdef SOUNDRIVE_DAC_MONO_EN
    v = (int'(ch_l0) + int'(ch_l1) + int'(ch_r0) + int'(ch_r1) - 512) * 64;
    if (right) v = v + 0;
`else
    if (right) v = (int'(ch_r0) + int'(ch_r1) - 256) * 128;
    else       v = (int'(ch_l0) + int'(ch_l1) - 256) * 128;
`endif
    return v[15:0];
  endfunction

  task automatic set_channels(input logic [31:0] v);
    {ch_l0, ch_l1, ch_r0, ch_r1} = v;
  endtask

  // Waits for the next strobe; on success, the channel values still present
  // are the snapshot just taken, so they define the frame now starting.
  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    while (!ok && budget > 0) begin
      @(negedge clk28);
      budget--;
      if (sample_strobe === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      strobe_cyc = cyc;
      exp_l      = model_slot(1'b0);
      exp_r      = model_slot(1'b1);
    end
  endtask

  task automatic start_capture();
    cap_data    = '0;
    cap_ws      = '0;
    cap_strobes = 0;
    per_min     = 1 << 30;
    per_max     = 0;
    last_rise   = -1;
    prev_bck    = dac_bck;
  endtask

  task automatic capture_bits(input int n, output bit ok);
    int got;
    int budget;
    got    = 0;
    budget = (n + 2) * BCK_PER;
    while (got < n && budget > 0) begin
      @(negedge clk28);
      budget--;
      if (sample_strobe === 1'b1) cap_strobes++;
      if (dac_bck === 1'b1 && prev_bck === 1'b0) begin
        cap_data = {cap_data[30:0], dac_data};
        cap_ws   = {cap_ws[30:0], dac_ws};
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        got++;
      end
      prev_bck = dac_bck;
    end
    ok = (got == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    set_channels(32'h80808080);
    repeat (3) @(negedge clk28);
    checks++;
    if ({dac_bck, dac_ws, dac_data, sample_strobe, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {dac_bck, dac_ws, dac_data, sample_strobe, busy});
    end
    en = 1'b1;
    repeat (3) @(negedge clk28);
    checks++;
    if ({dac_bck, dac_ws, dac_data, sample_strobe, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_priority_over_en got %b want 00000",
               {dac_bck, dac_ws, dac_data, sample_strobe, busy});
    end
    en  = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk28);
    checks++;
    if ({dac_bck, dac_ws, dac_data, sample_strobe, busy} !== 5'b0) begin
      errors++;
      $display("FAIL idle_en_low got %b want 00000",
               {dac_bck, dac_ws, dac_data, sample_strobe, busy});
    end
  endtask

  task automatic test_silence();
    bit ok;
    int s0;
    en = 1'b1;
    wait_strobe(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_strobe got none want strobe within 4 cycles");
    end
    s0 = strobe_cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_run got %b want 1", busy);
    end
    start_capture();
    capture_bits(32, ok);
    checks++;
    if (!ok || cap_data !== 32'h0) begin
      errors++;
      $display("FAIL silence_frame got %h (complete=%0d) want 00000000", cap_data, ok);
    end
    checks++;
    if (cap_ws !== WS_EXP) begin
      errors++;
      $display("FAIL silence_ws got %h want %h", cap_ws, WS_EXP);
    end
    checks++;
    if (per_min != BCK_PER || per_max != BCK_PER) begin
      errors++;
      $display("FAIL bck_period got %0d..%0d want %0d", per_min, per_max, BCK_PER);
    end
    checks++;
    if (cap_strobes != 0) begin
      errors++;
      $display("FAIL strobe_width got %0d extra strobe cycles want 0", cap_strobes);
    end
    wait_strobe(FRAME_CYC + 8, ok);
    checks++;
    if (!ok || strobe_cyc - s0 != FRAME_CYC) begin
      errors++;
      $display("FAIL strobe_spacing got %0d (seen=%0d) want %0d", strobe_cyc - s0, ok, FRAME_CYC);
    end
  endtask

  // Back-to-back frames; each new channel set is applied mid-frame and must
  // only show up in the following frame.
  task automatic test_stereo_mix(input int n_random);
    logic [31:0] vecs[$];
    logic [31:0] want;
    bit          ok;
    int          prev;
    vecs.push_back(32'hFFFF0000);
    vecs.push_back(32'h0000FFFF);
    vecs.push_back(32'h80808080);
    vecs.push_back(32'h00FF01FE);
    for (int i = 0; i < n_random; i++) vecs.push_back($urandom);
    vecs.push_back(32'h80808080);
    prev = -1;
    foreach (vecs[i]) begin
      wait_strobe(FRAME_CYC + 8, ok);
      checks++;
      if (!ok || (prev >= 0 && strobe_cyc - prev != FRAME_CYC)) begin
        errors++;
        $display("FAIL mix_spacing[%0d] got %0d (seen=%0d) want %0d", i, strobe_cyc - prev, ok, FRAME_CYC);
      end
      prev = strobe_cyc;
      want = {exp_l, exp_r};
      set_channels(vecs[i]);
      start_capture();
      capture_bits(32, ok);
      checks++;
      if (!ok || cap_data !== want) begin
        errors++;
        $display("FAIL mix_frame[%0d] got %h (complete=%0d) want %h", i, cap_data, ok, want);
      end
      checks++;
      if (cap_ws !== WS_EXP) begin
        errors++;
        $display("FAIL mix_ws[%0d] got %h want %h", i, cap_ws, WS_EXP);
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [31:0] want;
    bit          ok;
    wait_strobe(FRAME_CYC + 8, ok);
    set_channels(32'h80808080);
    wait_strobe(FRAME_CYC + 8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midchg_strobe got none want strobe");
    end
    want = {exp_l, exp_r};
    start_capture();
    capture_bits(5, ok);
    ch_l0 = 8'hC0;
    capture_bits(27, ok);
    checks++;
    if (!ok || cap_data !== want) begin
      errors++;
      $display("FAIL midchg_inflight got %h (complete=%0d) want %h", cap_data, ok, want);
    end
    wait_strobe(FRAME_CYC + 8, ok);
    want = {exp_l, exp_r};
    start_capture();
    capture_bits(32, ok);
    checks++;
    if (!ok || cap_data !== want) begin
      errors++;
      $display("FAIL midchg_next got %h (complete=%0d) want %h", cap_data, ok, want);
    end
  endtask

  task automatic test_en_drop();
    logic [31:0] want;
    bit          ok;
    int          s0;
    int          budget;
    int          strobes;
    wait_strobe(FRAME_CYC + 8, ok);
    set_channels($urandom);
    wait_strobe(FRAME_CYC + 8, ok);
    s0   = strobe_cyc;
    want = {exp_l, exp_r};
    start_capture();
    capture_bits(10, ok);
    en = 1'b0;
    capture_bits(22, ok);
    checks++;
    if (!ok || cap_data !== want) begin
      errors++;
      $display("FAIL endrop_frame got %h (complete=%0d) want %h", cap_data, ok, want);
    end
    budget = 4 * BCK_PER;
    while (busy === 1'b1 && budget > 0) begin
      @(negedge clk28);
      budget--;
    end
    checks++;
    if (busy !== 1'b0 || cyc - s0 != FRAME_CYC) begin
      errors++;
      $display("FAIL endrop_busy_fall got busy=%b after %0d cycles want 0 after %0d", busy, cyc - s0, FRAME_CYC);
    end
    checks++;
    if ({dac_bck, dac_ws, dac_data, sample_strobe} !== 4'b0) begin
      errors++;
      $display("FAIL endrop_outputs got %b want 0000", {dac_bck, dac_ws, dac_data, sample_strobe});
    end
    strobes = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge clk28);
      if (sample_strobe !== 1'b0 || busy !== 1'b0 || dac_bck !== 1'b0) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL endrop_quiet got %0d active cycles want 0", strobes);
    end
  endtask

  task automatic test_rst_midframe();
    logic [31:0] want;
    bit          ok;
    set_channels($urandom);
    en = 1'b1;
    wait_strobe(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_start_strobe got none want strobe within 4 cycles");
    end
    start_capture();
    capture_bits(21, ok);
    rst = 1'b1;
    @(negedge clk28);
    checks++;
    if ({dac_bck, dac_ws, dac_data, sample_strobe, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b want 00000",
               {dac_bck, dac_ws, dac_data, sample_strobe, busy});
    end
    rst = 1'b0;
    @(negedge clk28);
    checks++;
    if ({sample_strobe, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rst_restart got strobe,busy=%b want 11", {sample_strobe, busy});
    end
    want = {model_slot(1'b0), model_slot(1'b1)};
    start_capture();
    capture_bits(32, ok);
    checks++;
    if (!ok || cap_data !== want) begin
      errors++;
      $display("FAIL rst_restart_frame got %h (complete=%0d) want %h", cap_data, ok, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    set_channels(32'h80808080);
    test_reset();
    test_silence();
    test_stereo_mix(8);
    test_midframe_change();
    test_en_drop();
    test_rst_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
